frame_update_arbiter: RTL and testbench
=======================================

Name: frame_update_arbiter

Overview:
- Shares the single per-frame "update slot" among NUM_REQ game-object update engines (player, obstacles, score, LEDs).
- At each frame_tick (start of vertical blanking) it snapshots the pending requests and serves them one at a time, round-robin, with a req/grant/done handshake and a per-grant timeout.
- Sits between the VGA timing generator and the game-logic engines inside top; only one engine writes shared game state per grant window.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 1023, maximum cycles a grant is held without done before forced release.
- CNT_W, 10, width of the grant-cycle counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clkin  in  1  system clock (100 MHz).
- reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse at start of vertical blank.
- req  in  NUM_REQ  level request per engine; sampled only at frame_tick.
- done  in  NUM_REQ  one-cycle pulse from the granted engine when its update is finished.
- grant  out  NUM_REQ  one-hot grant, or zero.
- busy  out  1  high while any snapshot bit is still pending or a grant is active.
- timeout_pulse  out  1  one-cycle pulse when a grant is forcibly released.
- overrun_pulse  out  1  one-cycle pulse when frame_tick arrives while busy.
- stats  out  16  {overrun_count[7:0], timeout_count[7:0]}; all zero unless the feature macro is defined.

Behaviour:
- Reset: state=IDLE; grant=0; busy=0; both pulses=0; pending=0; rr_ptr=0; counters=0.
- States:
  - IDLE: on frame_tick, pending<=req, go SCAN. If req==0, pending stays 0 and the arbiter returns to IDLE on the next cycle.
  - SCAN: one cycle. Pick the first set pending bit searching upward from rr_ptr, with wrap-around. If one is found: grant<=onehot(idx), cnt<=0, go GRANT. If none: go IDLE.
  - GRANT: cnt increments each cycle.
    - done[idx] high: grant<=0, pending[idx]<=0, rr_ptr<=(idx+1) mod NUM_REQ, go SCAN.
    - Else cnt==TIMEOUT: same release, plus timeout_pulse=1 for that cycle.
- Latency: frame_tick → first grant visible is 2 cycles (IDLE→SCAN→grant registered). A released grant → next grant is 2 cycles.
- done on a non-granted bit, or done while in IDLE/SCAN, is ignored.
- done and cnt==TIMEOUT in the same cycle: treat as done; no timeout_pulse.
- rr_ptr persists across frames, so a requester served last in one frame gets lowest priority next frame.
- frame_tick while busy: overrun_pulse=1. The current grant continues; the new tick is discarded and does not reload pending.
- req changes after the snapshot have no effect until the next frame_tick.
- Mid-operation reset: grant drops to 0 on the next edge; all state is cleared.
- busy = (state!=IDLE).
- All outputs are registered.

Optional Feature:
- FRAME_ARB_STATS_EN defined: two 8-bit saturating counters.
  - overrun_count increments on each overrun_pulse; holds at 255.
  - timeout_count increments on each timeout_pulse; holds at 255.
  - Both are cleared by reset and drive stats.
- Not defined: counters are not instantiated; stats is tied to 16'h0000.

Decomposition:
- Shared package game_pkg: arbiter state encoding (IDLE, SCAN, GRANT), NUM_REQ default, requester index constants (REQ_PLAYER=0, REQ_OBST=1, REQ_SCORE=2, REQ_LED=3).
- Sub-module rr_priority_picker: combinational; inputs pending and rr_ptr; outputs found and idx. Keeps the wrap-around search testable on its own.

Test Plan:
- Basic service: req=4'b1010, rr_ptr=0, frame_tick, each engine pulses done 5 cycles after its grant → grant 0010 then 1000; busy falls; rr_ptr=0 afterwards.
- Fairness: req=4'b1111 held for 3 frames with immediate done → grant order 0,1,2,3 in every frame; the second frame starts at index 0 because rr_ptr wrapped to 0. With only 4'b1001 held → 0,3 then 0,3.
- Timeout: TIMEOUT=15, req=4'b0001, done never pulses → grant held exactly 16 cycles, timeout_pulse once, next SCAN finds nothing, busy=0.
- Overrun: grant active, second frame_tick → overrun_pulse=1 for one cycle, grant unchanged; with FRAME_ARB_STATS_EN, stats=16'h0100.
- Edge cases: done to a wrong bit is ignored; done coincident with cnt==TIMEOUT gives no timeout_pulse; reset asserted mid-GRANT → grant=0 one cycle later, and the next frame_tick restarts from index 0.
- Saturation (FRAME_ARB_STATS_EN): 300 forced timeouts → timeout_count reads 255.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-logic definitions: arbiter state encoding and requester slot indices.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    GRANT = 2'd2
  } arb_state_t;

  localparam int NUM_REQ_DEF = 4;

  localparam int REQ_PLAYER = 0;
  localparam int REQ_OBST   = 1;
  localparam int REQ_SCORE  = 2;
  localparam int REQ_LED    = 3;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: first set pending bit at or above rr_ptr, wrapping around.
module rr_priority_picker
  import game_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] w_pos;

  // Walk offsets from farthest to nearest so the nearest hit is the one that sticks.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    w_pos = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_pos = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (pending[w_pos]) begin
        found = 1'b1;
        idx   = w_pos;
      end
    end
  end

endmodule

// File: rtl/frame_update_arbiter.sv
// Per-frame update-slot arbiter: snapshots requests on frame_tick, grants them round-robin.
// Define FRAME_ARB_STATS_EN to build the saturating overrun/timeout counters behind stats.
module frame_update_arbiter
  import game_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  logic               clkin,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               timeout_pulse,
  output logic               overrun_pulse,
  output logic [15:0]        stats
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t         r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_pending, w_pending_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [IDX_W-1:0]   r_rr, w_rr_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_busy, r_timeout, r_overrun;
  logic               w_timeout_nxt, w_overrun_nxt;
  logic               w_found, w_release;
  logic [IDX_W-1:0]   w_pick_idx, w_idx_succ;

  rr_priority_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .pending (r_pending),
    .rr_ptr  (r_rr),
    .found   (w_found),
    .idx     (w_pick_idx)
  );

  assign w_idx_succ = (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + IDX_W'(1);
  assign w_release  = done[r_idx] || (r_cnt == CNT_W'(TIMEOUT));

  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_grant_nxt   = r_grant;
    w_idx_nxt     = r_idx;
    w_rr_nxt      = r_rr;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;
    w_overrun_nxt = frame_tick && (r_state != IDLE);
    unique case (r_state)
      IDLE: begin
        if (frame_tick) begin
          w_pending_nxt = req;
          w_state_nxt   = SCAN;
        end
      end
      SCAN: begin
        if (w_found) begin
          w_grant_nxt = NUM_REQ'(1) << w_pick_idx;
          w_idx_nxt   = w_pick_idx;
          w_cnt_nxt   = '0;
          w_state_nxt = GRANT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      GRANT: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        // A done arriving on the timeout cycle wins, so no timeout is reported then.
        if (w_release) begin
          w_grant_nxt          = '0;
          w_pending_nxt[r_idx] = 1'b0;
          w_rr_nxt             = w_idx_succ;
          w_timeout_nxt        = !done[r_idx];
          w_state_nxt          = SCAN;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_grant   <= '0;
      r_idx     <= '0;
      r_rr      <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_grant   <= w_grant_nxt;
      r_idx     <= w_idx_nxt;
      r_rr      <= w_rr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_busy    <= (w_state_nxt != IDLE);
      r_timeout <= w_timeout_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  assign grant         = r_grant;
  assign busy          = r_busy;
  assign timeout_pulse = r_timeout;
  assign overrun_pulse = r_overrun;

`ifdef FRAME_ARB_STATS_EN
  logic [7:0] r_ovr_cnt, r_to_cnt;

  // Counters step on the same edge that raises the matching pulse, and stick at 255.
  always_ff @(posedge clkin) begin
    if (reset) begin
      r_ovr_cnt <= '0;
      r_to_cnt  <= '0;
    end else begin
      if (w_overrun_nxt && (r_ovr_cnt != 8'hFF)) r_ovr_cnt <= r_ovr_cnt + 8'd1;
      if (w_timeout_nxt && (r_to_cnt != 8'hFF))  r_to_cnt  <= r_to_cnt + 8'd1;
    end
  end

  assign stats = {r_ovr_cnt, r_to_cnt};
`else
  assign stats = 16'h0000;
`endif

endmodule

// File: tb/tb_frame_update_arbiter.sv
// Self-checking bench for frame_update_arbiter: directed vector table, corner sequences, randomized frames.
module tb_frame_update_arbiter;

  localparam int NREQ = 4;
  localparam int TMO  = 15;
  localparam int CW   = 4;

  logic        clkin = 1'b0;
  logic        reset, frame_tick;
  logic [3:0]  req, done, grant;
  logic        busy, timeout_pulse, overrun_pulse;
  logic [15:0] stats;

  int testsRun = 0;
  int testsFailed = 0;
  bit statsEn;

  int mRr, oCnt, tCnt;
  bit opCarry;

  typedef struct {
    logic [3:0]  req;
    int          delay;
    logic [15:0] expSeq;
    int          expN;
  } vec_t;

  vec_t vecs[11];

  always #5 clkin = ~clkin;

  frame_update_arbiter #(.NUM_REQ(NREQ), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clkin         (clkin),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .req           (req),
    .done          (done),
    .grant         (grant),
    .busy          (busy),
    .timeout_pulse (timeout_pulse),
    .overrun_pulse (overrun_pulse),
    .stats         (stats)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyReset();
    reset = 1'b1;
    frame_tick = 1'b0;
    req = '0;
    done = '0;
    @(negedge clkin);
    @(negedge clkin);
    reset = 1'b0;
  endtask

  // One frame: snapshot r, then each grant is answered with done after 'delay' cycles of holding.
  task automatic applyStimulus(input logic [3:0] r, input int delay, output logic [15:0] seq,
                               output int n, output int badGap, output int badHold,
                               output int tpCnt, output int timedOut);
    int held, zeroRun;
    logic [3:0] g;
    seq = '0; n = 0; badGap = 0; badHold = 0; tpCnt = 0; timedOut = 1;
    held = 0; zeroRun = 0;
    req = r; frame_tick = 1'b1; done = '0;
    @(negedge clkin);
    frame_tick = 1'b0;
    req = 4'($urandom);
    for (int cyc = 0; cyc < 400; cyc++) begin
      g = grant;
      if (timeout_pulse) tpCnt++;
      done = 4'($urandom) & ~g;
      if (g != 4'b0) begin
        if (held == 0) begin
          if (zeroRun != 1) badGap++;
          if (n < 4) seq[4*n +: 4] = g;
          n++;
        end
        if (held == delay) done = done | g;
        if (held > delay) badHold++;
        held++;
        zeroRun = 0;
      end else begin
        if (held > 0 && held != delay + 1) badHold++;
        held = 0;
        zeroRun++;
        if (!busy) begin
          timedOut = 0;
          break;
        end
      end
      @(negedge clkin);
    end
    done = '0;
  endtask

  // Finish a frame already in progress, answering every new grant immediately.
  task automatic drainFrame(output logic [15:0] seq, output int n, output int timedOut);
    logic [3:0] prev;
    seq = '0; n = 0; timedOut = 1;
    prev = grant;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (grant != 4'b0 && prev == 4'b0) begin
        if (n < 4) seq[4*n +: 4] = grant;
        n++;
      end
      prev = grant;
      done = grant;
      if (!busy) begin
        timedOut = 0;
        break;
      end
      @(negedge clkin);
    end
    done = '0;
  endtask

  function automatic int pickDelay();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6) return int'($urandom_range(0, 5));
    if (r < 8) return TMO;
    if (r == 8) return TMO - 1;
    return TMO + 3;
  endfunction

  function automatic int sat8(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  // Reference: serve order follows from the round-robin rule; each grant lasts min(delay,TIMEOUT)+1
  // cycles, then one scan cycle; a pulse output shows on the cycle after its cause.
  task automatic runRandomFrame();
    logic [3:0] r, oh;
    logic [3:0] eG[$], dD[$], hM[$];
    bit eB[$], eT[$];
    int k, hold, e, ptr0;
    r = 4'($urandom);
    ptr0 = mRr;
    eG.push_back(4'b0); eB.push_back(1'b0); eT.push_back(1'b0); dD.push_back(4'b0); hM.push_back(4'b0);
    eG.push_back(4'b0); eB.push_back(1'b1); eT.push_back(1'b0); dD.push_back(4'b0); hM.push_back(4'b0);
    for (int i = 0; i < NREQ; i++) begin
      e = (ptr0 + i) % NREQ;
      if (r[e]) begin
        k = pickDelay();
        hold = ((k > TMO) ? TMO : k) + 1;
        oh = 4'(1 << e);
        for (int j = 0; j < hold; j++) begin
          eG.push_back(oh); eB.push_back(1'b1); eT.push_back(1'b0);
          dD.push_back((j == k) ? oh : 4'b0); hM.push_back(oh);
        end
        eG.push_back(4'b0); eB.push_back(1'b1); eT.push_back(k > TMO);
        dD.push_back(4'b0); hM.push_back(4'b0);
        mRr = (e + 1) % NREQ;
      end
    end
    for (int c = 0; c < eG.size(); c++) begin
      if (eT[c]) tCnt = sat8(tCnt);
      if (opCarry) oCnt = sat8(oCnt);
      checkOutput("rnd_grant", 32'(grant), 32'(eG[c]));
      checkOutput("rnd_busy", 32'(busy), 32'(eB[c]));
      checkOutput("rnd_timeout_pulse", 32'(timeout_pulse), 32'(eT[c]));
      checkOutput("rnd_overrun_pulse", 32'(overrun_pulse), 32'(opCarry));
      checkOutput("rnd_stats", 32'(stats), statsEn ? 32'({oCnt[7:0], tCnt[7:0]}) : 32'h0);
      frame_tick = (c == 0) ? 1'b1 : ($urandom_range(0, 11) == 0);
      opCarry = frame_tick && eB[c];
      req = (c == 0) ? r : 4'($urandom);
      done = dD[c] | (4'($urandom) & ~hM[c]);
      @(negedge clkin);
    end
  endtask

  initial begin
    logic [15:0] seq;
    int n, badGap, badHold, tpCnt, timedOut, gCnt, other;

`ifdef FRAME_ARB_STATS_EN
    statsEn = 1'b1;
`else
    statsEn = 1'b0;
`endif

    vecs[0]  = '{4'b1010, 5,   16'h0082, 2};
    vecs[1]  = '{4'b1111, 0,   16'h8421, 4};
    vecs[2]  = '{4'b1111, 0,   16'h8421, 4};
    vecs[3]  = '{4'b1111, 0,   16'h8421, 4};
    vecs[4]  = '{4'b1001, 1,   16'h0081, 2};
    vecs[5]  = '{4'b1001, 2,   16'h0081, 2};
    vecs[6]  = '{4'b0100, TMO, 16'h0004, 1};
    vecs[7]  = '{4'b1001, 0,   16'h0018, 2};
    vecs[8]  = '{4'b0000, 0,   16'h0000, 0};
    vecs[9]  = '{4'b0110, 3,   16'h0042, 2};
    vecs[10] = '{4'b1111, 0,   16'h4218, 4};

    applyReset();
    checkOutput("reset_grant", 32'(grant), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_timeout_pulse", 32'(timeout_pulse), 32'h0);
    checkOutput("reset_overrun_pulse", 32'(overrun_pulse), 32'h0);
    checkOutput("reset_stats", 32'(stats), 32'h0);

    for (int v = 0; v < 11; v++) begin
      applyStimulus(vecs[v].req, vecs[v].delay, seq, n, badGap, badHold, tpCnt, timedOut);
      checkOutput($sformatf("vec%0d_order", v), 32'(seq), 32'(vecs[v].expSeq));
      checkOutput($sformatf("vec%0d_count", v), 32'(n), 32'(vecs[v].expN));
      checkOutput($sformatf("vec%0d_latency", v), 32'(badGap), 32'h0);
      checkOutput($sformatf("vec%0d_hold", v), 32'(badHold), 32'h0);
      checkOutput($sformatf("vec%0d_no_timeout", v), 32'(tpCnt), 32'h0);
      checkOutput($sformatf("vec%0d_bounded", v), 32'(timedOut), 32'h0);
    end

    // Overrun: second tick during a grant pulses once and does not reload pending.
    applyReset();
    req = 4'b0011; frame_tick = 1'b1;
    @(negedge clkin);
    frame_tick = 1'b0;
    @(negedge clkin);
    checkOutput("ovr_grant_before", 32'(grant), 32'h1);
    frame_tick = 1'b1; req = 4'b1111;
    @(negedge clkin);
    frame_tick = 1'b0;
    checkOutput("ovr_pulse", 32'(overrun_pulse), 32'h1);
    checkOutput("ovr_grant_kept", 32'(grant), 32'h1);
    checkOutput("ovr_stats", 32'(stats), statsEn ? 32'h0100 : 32'h0);
    @(negedge clkin);
    checkOutput("ovr_pulse_single", 32'(overrun_pulse), 32'h0);
    checkOutput("ovr_grant_still", 32'(grant), 32'h1);
    drainFrame(seq, n, timedOut);
    checkOutput("ovr_rest_order", 32'(seq), 32'h0002);
    checkOutput("ovr_rest_count", 32'(n), 32'h1);
    checkOutput("ovr_bounded", 32'(timedOut), 32'h0);

    // Timeout: a grant with no done is held TIMEOUT+1 cycles and released with one pulse.
    applyReset();
    req = 4'b0001; frame_tick = 1'b1;
    @(negedge clkin);
    frame_tick = 1'b0; req = 4'b0;
    gCnt = 0; other = 0; tpCnt = 0; timedOut = 1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (grant == 4'b0001) gCnt++;
      else if (grant != 4'b0) other++;
      if (timeout_pulse) tpCnt++;
      if (!busy) begin
        timedOut = 0;
        break;
      end
      @(negedge clkin);
    end
    checkOutput("tmo_hold_cycles", 32'(gCnt), 32'(TMO + 1));
    checkOutput("tmo_pulse_count", 32'(tpCnt), 32'h1);
    checkOutput("tmo_other_grant", 32'(other), 32'h0);
    checkOutput("tmo_idle_after", 32'(timedOut), 32'h0);

    // Mid-grant reset clears the round-robin pointer as well as the grant.
    applyReset();
    applyStimulus(4'b0010, 0, seq, n, badGap, badHold, tpCnt, timedOut);
    checkOutput("rst_setup_order", 32'(seq), 32'h0002);
    req = 4'b1111; frame_tick = 1'b1;
    @(negedge clkin);
    frame_tick = 1'b0;
    @(negedge clkin);
    checkOutput("rst_pre_grant", 32'(grant), 32'h4);
    reset = 1'b1;
    @(negedge clkin);
    checkOutput("rst_grant_cleared", 32'(grant), 32'h0);
    checkOutput("rst_busy_cleared", 32'(busy), 32'h0);
    reset = 1'b0;
    applyStimulus(4'b1111, 0, seq, n, badGap, badHold, tpCnt, timedOut);
    checkOutput("rst_restart_order", 32'(seq), 32'h8421);
    checkOutput("rst_restart_bounded", 32'(timedOut), 32'h0);

    applyReset();
    mRr = 0; oCnt = 0; tCnt = 0; opCarry = 1'b0;
    for (int f = 0; f < 150; f++) runRandomFrame();

`ifdef FRAME_ARB_STATS_EN
    applyReset();
    for (int f = 0; f < 300; f++) begin
      req = 4'b0001; frame_tick = 1'b1;
      @(negedge clkin);
      frame_tick = 1'b0;
      timedOut = 1;
      for (int cyc = 0; cyc < 60; cyc++) begin
        if (!busy) begin
          timedOut = 0;
          break;
        end
        @(negedge clkin);
      end
      if (timedOut != 0) checkOutput("sat_frame_bounded", 32'(timedOut), 32'h0);
    end
    checkOutput("sat_timeout_count", 32'(stats), 32'h00FF);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
